regwrite_trace_fifo: RTL and testbench
======================================

// Module: regwrite_trace_fifo
// PURPOSE
//   Debug trace stage downstream of the processor/regfile wrapper: snoops the regfile write port
//   (ctrl_writeEnable, ctrl_writeReg, data_writeReg) once per processor cycle and buffers each
//   committed register write, with a commit-cycle stamp, into a FIFO. A host/bench drains entries
//   over a valid/ready interface. Runs on the undivided base clock; a one-cycle strobe marks each
//   processor-cycle boundary.
// PARAMETERS
//   DEPTH    16  FIFO entries; power of two, >= 2
//   STAMP_W  16  width of the processor-cycle stamp counter
// PORTS
//   clock             in   1        base clock (same clock driving imem/dmem)
//   reset             in   1        synchronous, active-high reset
//   commit_strobe     in   1        1-cycle pulse per processor cycle; write port sampled here
//   ctrl_writeEnable  in   1        regfile write enable from processor
//   ctrl_writeReg     in   5        regfile destination register
//   data_writeReg     in   32       regfile write data
//   trace_enable      in   1        1 = capture writes; 0 = ignore (stamp still counts)
//   flush             in   1        synchronous FIFO clear
//   clear_overflow    in   1        clears overflow flag and drop_count
//   trace_valid       out  1        head entry available
//   trace_ready       in   1        consumer accepts head entry
//   trace_reg         out  5        head entry: register number
//   trace_data        out  32       head entry: written value
//   trace_stamp       out  STAMP_W  head entry: stamp value at capture
//   fifo_count        out  log2(DEPTH)+1  entries held
//   overflow          out  1        sticky: at least one capture dropped
//   drop_count        out  16       dropped captures, saturating
// BEHAVIOUR
//   - Reset: pointers, fifo_count, stamp counter, overflow, drop_count = 0; trace_valid = 0;
//     trace_reg/data/stamp = 0 when empty. Storage array contents need no reset.
//   - Stamp: increments by 1 on every commit_strobe, wraps 2^STAMP_W-1 -> 0. Captured entry
//     carries the stamp value BEFORE that cycle's increment (first strobe after reset -> stamp 0).
//   - Capture (push) when commit_strobe & trace_enable & ctrl_writeEnable & (ctrl_writeReg != 0).
//     Writes to r0 are never recorded. Inputs sampled only in the strobe cycle.
//   - Output is first-word-fall-through: trace_valid = (fifo_count != 0); trace_reg/data/stamp
//     show the head entry combinationally from storage. Entry pushed at edge N is visible with
//     trace_valid = 1 after edge N (one-cycle latency into an empty FIFO).
//   - Pop when trace_valid & trace_ready; next entry (if any) presented the following cycle.
//     trace_ready with trace_valid = 0 has no effect.
//   - Pointers are log2(DEPTH) bits, wrap naturally; full = (fifo_count == DEPTH).
//   - Push & pop same cycle: both take effect, count unchanged; permitted when full (pop frees slot).
//     When empty, a simultaneous push is NOT popped in the same cycle (no bypass).
//   - Push while full without pop: entry dropped, overflow <= 1, drop_count += 1 saturating at 16'hFFFF.
//   - flush: pointers and fifo_count -> 0; has priority over push and pop in the same cycle
//     (that cycle's capture is discarded, not counted as a drop). overflow/drop_count unaffected.
//   - clear_overflow: overflow and drop_count -> 0; if a drop occurs the same cycle, the drop wins
//     (overflow = 1, drop_count = 1).
//   - reset asserted mid-stream: all state cleared next edge; buffered entries lost; stamp restarts at 0.
//   - trace_enable may toggle anytime; takes effect on the next strobe cycle.
// TESTING
//   1. Reset, then strobes with writes r3=0x0000_00AA, r5=0xDEAD_BEEF on strobes 0 and 2, ready=1
//      -> two entries (3,0xAA,stamp 0), (5,0xDEADBEEF,stamp 2); trace_valid one cycle after each push.
//   2. Write to r0 with enable=1 and any write with trace_enable=0 -> fifo_count stays 0, stamp still advances.
//   3. ready=0, DEPTH=16, 18 captures -> fifo_count=16, overflow=1, drop_count=2; drain returns the
//      first 16 in order; clear_overflow -> overflow=0, drop_count=0.
//   4. FIFO full, capture and pop in same cycle -> no drop, fifo_count stays 16, new entry appended at tail.
//   5. fifo_count=5, flush coinciding with a capture -> fifo_count=0, trace_valid=0, drop_count unchanged.
//   6. STAMP_W=4: 17 strobes with captures -> stamps 0..15 then 0 (wrap); reset mid-stream -> all outputs 0.

Source files
------------

// File: rtl/regwrite_trace_fifo.sv
// regwrite_trace_fifo
//   Debug trace buffer for regfile writes. On each commit_strobe, it checks the regfile
//   write port. Every committed write to a register other than r0 is pushed into a FIFO
//   together with the current processor-cycle stamp. The host drains the FIFO through a
//   first-word-fall-through valid/ready port.
//
// Ports
//   clock, reset          base clock; synchronous active-high reset
//   commit_strobe         one-cycle pulse per processor cycle (write port sampled here)
//   ctrl_writeEnable      regfile write enable
//   ctrl_writeReg         regfile destination register
//   data_writeReg         regfile write data
//   trace_enable          capture gate (the stamp keeps counting while it is low)
//   flush                 clears the FIFO contents; overflow state is kept
//   clear_overflow        clears overflow and drop_count
//   trace_valid/ready     head-entry handshake
//   trace_reg/data/stamp  head entry, or zero when the FIFO is empty
//   fifo_count            number of entries held
//   overflow, drop_count  sticky drop flag and saturating drop counter
module regwrite_trace_fifo #(
  parameter int DEPTH   = 16,
  parameter int STAMP_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     commit_strobe,
  input  logic                     ctrl_writeEnable,
  input  logic [4:0]               ctrl_writeReg,
  input  logic [31:0]              data_writeReg,
  input  logic                     trace_enable,
  input  logic                     flush,
  input  logic                     clear_overflow,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [4:0]               trace_reg,
  output logic [31:0]              trace_data,
  output logic [STAMP_W-1:0]       trace_stamp,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow,
  output logic [15:0]              drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 5 + 32 + STAMP_W;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [EW-1:0]      mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [STAMP_W-1:0] stamp;
  logic [EW-1:0]      head;

  logic capture_p0;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Stage p0: decide what happens this cycle. Flush overrides everything.
  // When the FIFO is full, a pop in the same cycle frees a slot for the push.
  assign capture_p0 = commit_strobe & trace_enable & ctrl_writeEnable & (ctrl_writeReg != 5'd0);
  assign full       = (fifo_count == FULL_CNT);
  assign pop        = trace_valid & trace_ready & ~flush;
  assign push       = capture_p0 & ~flush & (~full | pop);
  assign drop       = capture_p0 & ~flush & full & ~pop;

  assign trace_valid = (fifo_count != '0);
  assign head        = mem[rd_ptr];
  assign trace_reg   = trace_valid ? head[EW-1 -: 5]       : 5'd0;
  assign trace_data  = trace_valid ? head[STAMP_W +: 32]   : 32'd0;
  assign trace_stamp = trace_valid ? head[STAMP_W-1:0]     : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      stamp      <= '0;
      overflow   <= 1'b0;
      drop_count <= 16'd0;
    end else begin
      if (commit_strobe) stamp <= stamp + STAMP_W'(1);
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
          2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
          default: ;
        endcase
      end
      // A drop in the same cycle as clear_overflow wins and restarts the count at 1.
      if (drop) begin
        overflow   <= 1'b1;
        drop_count <= clear_overflow ? 16'd1 : sat_inc16(drop_count);
      end else if (clear_overflow) begin
        overflow   <= 1'b0;
        drop_count <= 16'd0;
      end
    end
  end

  // Storage: data path only, no reset. The entry carries the stamp from before this strobe's increment.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {ctrl_writeReg, data_writeReg, stamp};
  end

endmodule

// File: tb/tb_regwrite_trace_fifo.sv
module tb_regwrite_trace_fifo;
  localparam int DEPTH = 16;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, commit_strobe, ctrl_writeEnable, trace_enable, flush, clear_overflow, trace_ready;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;

  logic        valid_a, ovf_a, valid_b, ovf_b;
  logic [4:0]  reg_a, reg_b, cnt_a, cnt_b;
  logic [31:0] data_a, data_b;
  logic [15:0] stamp_a, drops_a, drops_b;
  logic [3:0]  stamp_b;

  regwrite_trace_fifo #(.DEPTH(DEPTH), .STAMP_W(16)) u_dut (
    .clock(clock), .reset(reset), .commit_strobe(commit_strobe), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg), .trace_enable(trace_enable),
    .flush(flush), .clear_overflow(clear_overflow), .trace_valid(valid_a), .trace_ready(trace_ready),
    .trace_reg(reg_a), .trace_data(data_a), .trace_stamp(stamp_a), .fifo_count(cnt_a),
    .overflow(ovf_a), .drop_count(drops_a));

  regwrite_trace_fifo #(.DEPTH(DEPTH), .STAMP_W(4)) u_dut4 (
    .clock(clock), .reset(reset), .commit_strobe(commit_strobe), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg), .trace_enable(trace_enable),
    .flush(flush), .clear_overflow(clear_overflow), .trace_valid(valid_b), .trace_ready(trace_ready),
    .trace_reg(reg_b), .trace_data(data_b), .trace_stamp(stamp_b), .fifo_count(cnt_b),
    .overflow(ovf_b), .drop_count(drops_b));

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model: a queue of entries plus counters, updated from the behavioural rules.
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
    int unsigned s;
  } entry_t;
  entry_t      q[$];
  int unsigned m_stamp = 0;
  logic        m_ovf   = 1'b0;
  int unsigned m_drops = 0;

  task automatic set_in(input logic stb, input logic we, input logic [4:0] r, input logic [31:0] d,
                        input logic en, input logic rdy, input logic fl, input logic clr);
    commit_strobe = stb; ctrl_writeEnable = we; ctrl_writeReg = r; data_writeReg = d;
    trace_enable = en; trace_ready = rdy; flush = fl; clear_overflow = clr;
  endtask

  // Apply the current inputs to the model, then clock the DUT and settle just after the edge.
  task automatic step();
    bit     cap, pop, drop;
    entry_t e;
    cap  = commit_strobe && trace_enable && ctrl_writeEnable && (ctrl_writeReg != 5'd0);
    pop  = (q.size() != 0) && trace_ready;
    drop = 1'b0;
    if (reset) begin
      q.delete(); m_stamp = 0; m_ovf = 1'b0; m_drops = 0;
    end else begin
      if (flush) q.delete();
      else begin
        if (pop) q.delete(0);
        if (cap) begin
          if (q.size() < DEPTH) begin
            e.r = ctrl_writeReg; e.d = data_writeReg; e.s = m_stamp;
            q.push_back(e);
          end else drop = 1'b1;
        end
      end
      if (clear_overflow) begin m_ovf = 1'b0; m_drops = 0; end
      if (drop) begin m_ovf = 1'b1; if (m_drops < 65535) m_drops++; end
      if (commit_strobe) m_stamp++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [4:0]  er;
    logic [31:0] ed;
    int unsigned es;
    er = 5'd0; ed = 32'd0; es = 0;
    if (q.size() != 0) begin er = q[0].r; ed = q[0].d; es = q[0].s; end
    chk({tag, "_valid"}, 32'(valid_a), 32'(q.size() != 0));
    chk({tag, "_count"}, 32'(cnt_a), 32'(q.size()));
    chk({tag, "_reg"},   32'(reg_a), 32'(er));
    chk({tag, "_data"},  data_a, ed);
    chk({tag, "_stamp"}, 32'(stamp_a), es & 32'hFFFF);
    chk({tag, "_stamp4"}, 32'(stamp_b), es & 32'hF);
    chk({tag, "_ovf"},   32'(ovf_a), 32'(m_ovf));
    chk({tag, "_drops"}, 32'(drops_a), m_drops);
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 1, 0, 0, 0);
    reset = 1'b1; step(); step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        stb, we, en, rdy;
    logic [4:0]  r;
    logic [31:0] d;
    logic        ev;
    int          ecnt;
    logic [4:0]  er;
    logic [31:0] ed;
    int          es;
  } vec_t;
  vec_t tbl[10];

  initial begin
    tbl[0] = '{1, 1, 1, 1, 5'd3, 32'h0000_00AA, 1, 1, 5'd3, 32'h0000_00AA, 0};
    tbl[1] = '{0, 0, 1, 1, 5'd0, 32'h0,         0, 0, 5'd0, 32'h0,         0};
    tbl[2] = '{1, 0, 1, 1, 5'd4, 32'h1111,      0, 0, 5'd0, 32'h0,         0};
    tbl[3] = '{0, 0, 1, 1, 5'd0, 32'h0,         0, 0, 5'd0, 32'h0,         0};
    tbl[4] = '{1, 1, 1, 1, 5'd5, 32'hDEAD_BEEF, 1, 1, 5'd5, 32'hDEAD_BEEF, 2};
    tbl[5] = '{0, 0, 1, 1, 5'd0, 32'h0,         0, 0, 5'd0, 32'h0,         0};
    tbl[6] = '{1, 1, 1, 1, 5'd0, 32'h0000_0123, 0, 0, 5'd0, 32'h0,         0};
    tbl[7] = '{1, 1, 0, 1, 5'd7, 32'h0000_0777, 0, 0, 5'd0, 32'h0,         0};
    tbl[8] = '{1, 1, 1, 0, 5'd9, 32'h0000_0055, 1, 1, 5'd9, 32'h0000_0055, 5};
    tbl[9] = '{0, 0, 1, 1, 5'd0, 32'h0,         0, 0, 5'd0, 32'h0,         0};

    do_reset();
    chk("rst_valid", 32'(valid_a), 0);
    chk("rst_count", 32'(cnt_a), 0);
    chk("rst_ovf",   32'(ovf_a), 0);
    chk("rst_drops", 32'(drops_a), 0);
    chk("rst_reg",   32'(reg_a), 0);
    chk("rst_data",  data_a, 0);
    chk("rst_stamp", 32'(stamp_a), 0);

    // Basic capture, r0 filtering and trace_enable gating.
    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].stb, tbl[i].we, tbl[i].r, tbl[i].d, tbl[i].en, tbl[i].rdy, 0, 0);
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(valid_a), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_count", i), 32'(cnt_a), 32'(tbl[i].ecnt));
      chk($sformatf("tbl%0d_reg", i),   32'(reg_a), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_data", i),  data_a, tbl[i].ed);
      chk($sformatf("tbl%0d_stamp", i), 32'(stamp_a), 32'(tbl[i].es));
    end

    // Overflow: 18 captures into a stalled FIFO, a drop coinciding with clear, then drain.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      set_in(1, 1, 5'((i % 31) + 1), $urandom, 1, 0, 0, 0);
      step();
    end
    chk("ovf_count", 32'(cnt_a), 16);
    chk("ovf_flag",  32'(ovf_a), 1);
    chk("ovf_drops", 32'(drops_a), 2);
    set_in(1, 1, 5'd20, 32'h1234_5678, 1, 0, 0, 1);
    step();
    chk("clr_drop_flag",  32'(ovf_a), 1);
    chk("clr_drop_drops", 32'(drops_a), 1);
    for (int i = 0; i < 16; i++) begin
      check_model($sformatf("drain%0d", i));
      if (i == 0) chk("drain_first_reg", 32'(reg_a), 1);
      set_in(0, 0, 0, 0, 1, 1, 0, 0);
      step();
    end
    chk("drain_empty", 32'(cnt_a), 0);
    set_in(0, 0, 0, 0, 1, 0, 0, 1);
    step();
    chk("clr_flag",  32'(ovf_a), 0);
    chk("clr_drops", 32'(drops_a), 0);

    // Full FIFO: capture and pop in the same cycle.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_in(1, 1, 5'(i + 1), $urandom, 1, 0, 0, 0);
      step();
    end
    set_in(1, 1, 5'd30, 32'h0000_CAFE, 1, 1, 0, 0);
    step();
    chk("fullpp_count", 32'(cnt_a), 16);
    chk("fullpp_ovf",   32'(ovf_a), 0);
    chk("fullpp_drops", 32'(drops_a), 0);
    chk("fullpp_head",  32'(reg_a), 2);
    for (int i = 0; i < 16; i++) begin
      check_model($sformatf("fpdrain%0d", i));
      if (i == 15) begin
        chk("fullpp_tail_reg",  32'(reg_a), 30);
        chk("fullpp_tail_data", data_a, 32'h0000_CAFE);
      end
      set_in(0, 0, 0, 0, 1, 1, 0, 0);
      step();
    end

    // Flush: one prior drop, flush while full with capture, then flush at count 5 with capture.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_in(1, 1, 5'd11, $urandom, 1, 0, 0, 0);
      step();
    end
    set_in(1, 1, 5'd12, 32'hAAAA, 1, 0, 1, 0);
    step();
    chk("flfull_count", 32'(cnt_a), 0);
    chk("flfull_drops", 32'(drops_a), 1);
    for (int i = 0; i < 5; i++) begin
      set_in(1, 1, 5'd13, $urandom, 1, 0, 0, 0);
      step();
    end
    chk("fl5_pre_count", 32'(cnt_a), 5);
    set_in(1, 1, 5'd14, 32'hBBBB, 1, 1, 1, 0);
    step();
    chk("fl5_count", 32'(cnt_a), 0);
    chk("fl5_valid", 32'(valid_a), 0);
    chk("fl5_drops", 32'(drops_a), 1);
    chk("fl5_ovf",   32'(ovf_a), 1);
    check_model("fl5");

    // Stamp wrap on the 4-bit instance, then reset mid-stream.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      set_in(1, 1, 5'd6, 32'(i), 1, 1, 0, 0);
      step();
      chk($sformatf("wrap%0d_stamp4", i), 32'(stamp_b), 32'(i % 16));
      chk($sformatf("wrap%0d_stamp", i),  32'(stamp_a), 32'(i));
      check_model($sformatf("wrap%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 5'd8, $urandom, 1, 0, 0, 0);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mrst_valid", 32'(valid_a), 0);
    chk("mrst_count", 32'(cnt_a), 0);
    chk("mrst_reg",   32'(reg_a), 0);
    chk("mrst_data",  data_a, 0);
    chk("mrst_stamp", 32'(stamp_a), 0);
    chk("mrst_stamp4", 32'(stamp_b), 0);
    set_in(1, 1, 5'd17, 32'h7777, 1, 0, 0, 0);
    step();
    chk("mrst_restamp",  32'(stamp_a), 0);
    chk("mrst_restamp4", 32'(stamp_b), 0);
    chk("mrst_reg2",     32'(reg_a), 17);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      set_in(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) != 0),
             5'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 31)), $urandom,
             1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 49) == 0));
      reset = 1'($urandom_range(0, 299) == 0);
      step();
      check_model($sformatf("rnd%0d", i));
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
